// File: rtl/s_pea_stream_sink.sv
// PEA stream sink: accepts PE results into a FWFT FIFO, generates pea_ready backpressure and
// counts job elements. Optional stall statistics under S_PEA_SINK_STATS_EN.
module s_pea_stream_sink #(
  parameter int unsigned N_BITS = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_elem_i,
  input  logic [N_BITS-1:0] pe_res_i,
  input  logic              pe_valid_i,
  output logic              pea_ready_o,
  output logic [N_BITS-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              r_state;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_remaining;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [FILL_W-1:0]   r_count;
  logic [N_BITS-1:0]   r_mem [DEPTH];

  logic                w_push;
  logic                w_pop;
  logic [FILL_W-1:0]   w_count_d;

  assign pea_ready_o = (r_state == StRun) && (r_count < FILL_W'(DEPTH));
  assign out_valid_o = (r_count != '0);
  assign out_data_o  = out_valid_o ? r_mem[r_rd_ptr] : '0;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

  assign w_push = pe_valid_i && pea_ready_o;
  assign w_pop  = out_valid_o && out_ready_i;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + FILL_W'(1);
      2'b01:   w_count_d = r_count - FILL_W'(1);
      default: w_count_d = r_count;
    endcase
  end

  // Storage is not reset: out_data_o is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pe_res_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start_i) begin
            r_busy <= 1'b1;
            if (n_elem_i != '0) begin
              r_remaining <= n_elem_i;
              r_state     <= StRun;
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_push) begin
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          // Look at the post-pop fill so a same-cycle pop of the last word completes the job.
          if (w_count_d == '0) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef S_PEA_SINK_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
    end else if ((r_state == StIdle) && start_i && (n_elem_i != '0)) begin
      r_stall_cnt <= '0;
    end else if ((r_state == StRun) && pe_valid_i && !pea_ready_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_s_pea_stream_sink.sv
// Self-checking bench for s_pea_stream_sink: a directed vector table plus scoreboarded sequences
// for full-FIFO, steady push/pop, and asynchronous reset mid-job.
module tb_s_pea_stream_sink;

  localparam int unsigned DEPTH = 8;

  logic        clk_i;
  logic        rst_n_i;
  logic        start_i;
  logic [15:0] n_elem_i;
  logic [31:0] pe_res_i;
  logic        pe_valid_i;
  logic        pea_ready_o;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] stall_cnt_o;

  s_pea_stream_sink #(
    .N_BITS(32),
    .DEPTH (DEPTH),
    .CNT_W (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .n_elem_i   (n_elem_i),
    .pe_res_i   (pe_res_i),
    .pe_valid_i (pe_valid_i),
    .pea_ready_o(pea_ready_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start;
    logic [15:0] n;
    logic        valid;
    logic [31:0] res;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t        vecs[$];
  int          checks   = 0;
  int          failures = 0;

  // Scoreboard state for the sequenced tests
  logic [31:0] m_q[$];
  int          m_rem;
  int          m_acc;
  int          m_stall;
  bit          m_run;
  logic [31:0] m_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void add(input logic st, input logic [15:0] n, input logic v,
                              input logic [31:0] r, input logic o, input logic er,
                              input logic eov, input logic [31:0] eod, input logic eb,
                              input logic ed);
    vec_t x;
    x.start = st; x.n = n; x.valid = v; x.res = r; x.ordy = o;
    x.e_rdy = er; x.e_ov = eov; x.e_od = eod; x.e_busy = eb; x.e_done = ed;
    vecs.push_back(x);
  endfunction

  task automatic start_job(input int n, input logic [31:0] base);
    @(negedge clk_i);
    start_i    = 1'b1;
    n_elem_i   = 16'(n);
    pe_valid_i = 1'b0;
    out_ready_i = 1'b0;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    m_q.delete();
    m_rem   = n;
    m_acc   = 0;
    m_stall = 0;
    m_run   = (n != 0);
    m_base  = base;
  endtask

  task automatic cycle(input bit ordy);
    logic        v;
    logic [31:0] d;
    logic [31:0] exp_od;
    bit          exp_rdy;
    bit          exp_ov;
    v = (m_rem > 0);
    d = m_base + 32'(m_acc);
    @(negedge clk_i);
    start_i     = 1'b0;
    pe_valid_i  = v;
    pe_res_i    = d;
    out_ready_i = ordy;
    #1;
    exp_rdy = m_run && (m_q.size() < DEPTH);
    exp_ov  = (m_q.size() != 0);
    exp_od  = 32'h0;
    if (exp_ov) exp_od = m_q[0];
    chk("pea_ready", {31'h0, pea_ready_o}, {31'h0, exp_rdy});
    chk("out_valid", {31'h0, out_valid_o}, {31'h0, exp_ov});
    chk("out_data", out_data_o, exp_od);
    if (m_run && v && !exp_rdy) m_stall++;
    @(posedge clk_i);
    if (exp_ov && ordy) void'(m_q.pop_front());
    if (v && exp_rdy) begin
      m_q.push_back(d);
      m_acc++;
      m_rem--;
      if (m_rem == 0) m_run = 1'b0;
    end
  endtask

  task automatic drain_and_done();
    int guard;
    guard = 0;
    while ((m_rem > 0 || m_q.size() > 0) && guard < 200) begin
      cycle(1'b1);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d cycles expected fewer than 200", guard);
    end
    @(negedge clk_i);
    pe_valid_i = 1'b0;
    #1;
    chk("done_pulse", {31'h0, done_o}, 32'h1);
    chk("done_busy", {31'h0, busy_o}, 32'h1);
    @(negedge clk_i);
    #1;
    chk("done_clear", {31'h0, done_o}, 32'h0);
    chk("idle_busy", {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; n_elem_i = '0; pe_res_i = '0;
    pe_valid_i = 1'b0; out_ready_i = 1'b0;
    m_rem = 0; m_acc = 0; m_stall = 0; m_run = 1'b0; m_base = '0;

    // Basic job, n=4, a stray start mid-job must be ignored
    add(1, 4, 0, 0,     1, 0, 0, 0,     0, 0);
    add(0, 0, 1, 'h10,  1, 1, 0, 0,     1, 0);
    add(1, 9, 1, 'h11,  1, 1, 1, 'h10,  1, 0);
    add(0, 0, 1, 'h12,  1, 1, 1, 'h11,  1, 0);
    add(0, 0, 1, 'h13,  1, 1, 1, 'h12,  1, 0);
    add(0, 0, 0, 0,     1, 0, 1, 'h13,  1, 0);
    add(0, 0, 0, 0,     1, 0, 0, 0,     1, 1);
    add(0, 0, 0, 0,     1, 0, 0, 0,     0, 0);
    // Zero-length job
    add(1, 0, 0, 0,     1, 0, 0, 0,     0, 0);
    add(0, 0, 0, 0,     1, 0, 0, 0,     1, 1);
    add(0, 0, 0, 0,     1, 0, 0, 0,     0, 0);
    // Extra data after the last of 3 elements is never taken
    add(1, 3, 1, 'h20,  1, 0, 0, 0,     0, 0);
    add(0, 0, 1, 'h20,  1, 1, 0, 0,     1, 0);
    add(0, 0, 1, 'h21,  1, 1, 1, 'h20,  1, 0);
    add(0, 0, 1, 'h22,  1, 1, 1, 'h21,  1, 0);
    add(0, 0, 1, 'h23,  1, 0, 1, 'h22,  1, 0);
    add(0, 0, 1, 'h23,  1, 0, 0, 0,     1, 1);
    add(0, 0, 1, 'h23,  1, 0, 0, 0,     0, 0);
    add(0, 0, 0, 0,     1, 0, 0, 0,     0, 0);

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", {31'h0, pea_ready_o}, 32'h0);
    chk("rst_valid", {31'h0, out_valid_o}, 32'h0);
    chk("rst_data", out_data_o, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_stall", stall_cnt_o, 32'h0);
    rst_n_i = 1'b1;
    @(posedge clk_i);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      start_i     = vecs[i].start;
      n_elem_i    = vecs[i].n;
      pe_valid_i  = vecs[i].valid;
      pe_res_i    = vecs[i].res;
      out_ready_i = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_ready", i), {31'h0, pea_ready_o}, {31'h0, vecs[i].e_rdy});
      chk($sformatf("v%0d_valid", i), {31'h0, out_valid_o}, {31'h0, vecs[i].e_ov});
      chk($sformatf("v%0d_data", i), out_data_o, vecs[i].e_od);
      chk($sformatf("v%0d_busy", i), {31'h0, busy_o}, {31'h0, vecs[i].e_busy});
      chk($sformatf("v%0d_done", i), {31'h0, done_o}, {31'h0, vecs[i].e_done});
      @(posedge clk_i);
    end
    chk("table_stall", stall_cnt_o, 32'h0);

    // Full FIFO: 8 accepted, then 6 stalled cycles, then release downstream
    start_job(12, 32'h30);
    repeat (8) cycle(1'b0);
    repeat (6) cycle(1'b0);
    drain_and_done();
`ifdef S_PEA_SINK_STATS_EN
    chk("full_stall", stall_cnt_o, 32'(m_stall));
`else
    chk("full_stall_off", stall_cnt_o, 32'h0);
`endif

    // Steady push/pop at DEPTH-1 fill for 20 cycles
    start_job(40, 32'h100);
    repeat (DEPTH - 1) cycle(1'b0);
    repeat (20) cycle(1'b1);
    drain_and_done();
    chk("pp_stall", stall_cnt_o, 32'h0);

    // Asynchronous reset after 2 of 5 beats
    start_job(5, 32'h40);
    repeat (2) cycle(1'b0);
    @(negedge clk_i);
    pe_valid_i = 1'b1;
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_valid", {31'h0, out_valid_o}, 32'h0);
    chk("arst_busy", {31'h0, busy_o}, 32'h0);
    chk("arst_ready", {31'h0, pea_ready_o}, 32'h0);
    chk("arst_data", out_data_o, 32'h0);
    @(negedge clk_i);
    pe_valid_i = 1'b0;
    rst_n_i = 1'b1;
    m_q.delete();
    m_run = 1'b0;
    m_rem = 0;
    start_job(2, 32'h50);
    drain_and_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
